// File: rtl/writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : writeback_arbiter
// Description : Writeback stage that merges results from NUM_SRC producers
//               onto NUM_WP register-file write ports. Every producer owns a
//               small circular FIFO so results are never dropped. FIFO heads
//               are granted by a round-robin scan that never grants two writes
//               to the same destination register in one cycle.
//
// Ports       : clk        - clock
//               rstn       - asynchronous active-low reset
//               interlock  - pipeline stall, suppresses all grants and pops
//               src_valid  - per-source result valid
//               src_ready  - per-source FIFO has room (count < DEPTH)
//               src_rd     - per-source destination register, [i*RW +: RW]
//               src_data   - per-source result data, [i*XLEN +: XLEN]
//               wp_en      - registered write-port enable
//               wp_addr    - registered write address, [k*RW +: RW]
//               wp_data    - registered write data, [k*XLEN +: XLEN]
//               pend_mask  - bit r set while any FIFO holds an entry for r
//               busy       - any FIFO non-empty
//
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_arbiter #(
    parameter int NUM_SRC          = 8,
    parameter int NUM_WP           = 2,
    parameter int XLEN             = 32,
    parameter int NREG             = 32,
    parameter int DEPTH            = 4,
    parameter bit ZERO_REG_DISCARD = 1'b1,
    localparam int RW              = $clog2(NREG)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     interlock,
    input  logic [NUM_SRC-1:0]       src_valid,
    output logic [NUM_SRC-1:0]       src_ready,
    input  logic [NUM_SRC*RW-1:0]    src_rd,
    input  logic [NUM_SRC*XLEN-1:0]  src_data,
    output logic [NUM_WP-1:0]        wp_en,
    output logic [NUM_WP*RW-1:0]     wp_addr,
    output logic [NUM_WP*XLEN-1:0]   wp_data,
    output logic [NREG-1:0]          pend_mask,
    output logic                     busy
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    // ------------------------------------------------------------------------
    // Per-source views exported from the FIFO generate blocks
    // ------------------------------------------------------------------------
    logic [NUM_SRC-1:0] w_push;
    logic [NUM_SRC-1:0] w_pop;
    logic [NUM_SRC-1:0] w_nonempty;
    logic [RW-1:0]      w_head_rd   [NUM_SRC];
    logic [XLEN-1:0]    w_head_data [NUM_SRC];
    logic [NREG-1:0]    w_pend_src  [NUM_SRC];

    // ------------------------------------------------------------------------
    // Source FIFOs
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [RW-1:0]      r_rd_mem   [DEPTH];
        logic [XLEN-1:0]    r_data_mem [DEPTH];
        logic [c_PTR_W-1:0] r_wptr;
        logic [c_PTR_W-1:0] r_rptr;
        logic [c_CNT_W-1:0] r_count;
        logic [NREG-1:0]    w_pend;

        // Ready depends only on the registered count, so a pop in the same
        // cycle never makes room for an extra push.
        assign src_ready[i]   = (r_count < c_CNT_W'(DEPTH));
        assign w_push[i]      = src_valid[i] & src_ready[i];
        assign w_nonempty[i]  = (r_count != '0);
        assign w_head_rd[i]   = r_rd_mem[r_rptr];
        assign w_head_data[i] = r_data_mem[r_rptr];
        assign w_pend_src[i]  = w_pend;

        // Storage carries no reset; validity is tracked by pointers/count.
        always_ff @(posedge clk) begin
            if (w_push[i]) begin
                r_rd_mem[r_wptr]   <= src_rd[i*RW +: RW];
                r_data_mem[r_wptr] <= src_data[i*XLEN +: XLEN];
            end
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push[i]) begin
                    r_wptr <= r_wptr + 1'b1;
                end
                if (w_pop[i]) begin
                    r_rptr <= r_rptr + 1'b1;
                end
                case ({w_push[i], w_pop[i]})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end

        // A slot is live when its distance from the read pointer (modulo the
        // FIFO depth) is below the occupancy count.
        always_comb begin
            logic [c_PTR_W-1:0] w_off;
            w_pend = '0;
            w_off  = '0;
            for (int d = 0; d < DEPTH; d++) begin
                w_off = c_PTR_W'(d) - r_rptr;
                if ({1'b0, w_off} < r_count) begin
                    w_pend[r_rd_mem[d]] = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Round-robin grant scan
    // ------------------------------------------------------------------------
    logic [c_SRC_W-1:0]     r_rr;
    logic [c_SRC_W-1:0]     w_rr_next;
    logic                   w_any_grant;
    logic [NUM_WP-1:0]      w_grant_wr;
    logic [NUM_WP*RW-1:0]   w_grant_addr;
    logic [NUM_WP*XLEN-1:0] w_grant_data;

    always_comb begin
        logic [NREG-1:0] w_used_rd;
        logic [RW-1:0]   w_hrd;
        logic [XLEN-1:0] w_hdata;
        logic            w_hvalid;
        int              n_grant;
        int              scan_idx;
        int              last_idx;

        w_pop        = '0;
        w_grant_wr   = '0;
        w_grant_addr = '0;
        w_grant_data = '0;
        w_used_rd    = '0;
        w_hrd        = '0;
        w_hdata      = '0;
        w_hvalid     = 1'b0;
        n_grant      = 0;
        scan_idx     = 0;
        last_idx     = 0;
        w_any_grant  = 1'b0;

        if (!interlock) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                scan_idx = int'(r_rr) + k;
                if (scan_idx >= NUM_SRC) begin
                    scan_idx = scan_idx - NUM_SRC;
                end

                // Select the scanned head with constant indices only.
                w_hvalid = 1'b0;
                w_hrd    = '0;
                w_hdata  = '0;
                for (int s = 0; s < NUM_SRC; s++) begin
                    if (s == scan_idx) begin
                        w_hvalid = w_nonempty[s];
                        w_hrd    = w_head_rd[s];
                        w_hdata  = w_head_data[s];
                    end
                end

                // A head whose rd is already being written this cycle stays
                // queued and is retried on a later scan.
                if (w_hvalid && (n_grant < NUM_WP) && !w_used_rd[w_hrd]) begin
                    w_used_rd[w_hrd] = 1'b1;
                    for (int s = 0; s < NUM_SRC; s++) begin
                        if (s == scan_idx) begin
                            w_pop[s] = 1'b1;
                        end
                    end
                    for (int p = 0; p < NUM_WP; p++) begin
                        // Register-0 results use up the port but are not
                        // written, so the port stays idle for that cycle.
                        if ((p == n_grant) &&
                            !(ZERO_REG_DISCARD && (w_hrd == '0))) begin
                            w_grant_wr[p]                 = 1'b1;
                            w_grant_addr[p*RW +: RW]      = w_hrd;
                            w_grant_data[p*XLEN +: XLEN]  = w_hdata;
                        end
                    end
                    n_grant     = n_grant + 1;
                    last_idx    = scan_idx;
                    w_any_grant = 1'b1;
                end
            end
        end

        w_rr_next = c_SRC_W'((last_idx + 1) % NUM_SRC);
    end

    // ------------------------------------------------------------------------
    // Registered write ports and round-robin pointer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rr    <= '0;
            wp_en   <= '0;
            wp_addr <= '0;
            wp_data <= '0;
        end else begin
            wp_en   <= w_grant_wr;
            wp_addr <= w_grant_addr;
            wp_data <= w_grant_data;
            if (w_any_grant) begin
                r_rr <= w_rr_next;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Scoreboard-facing status
    // ------------------------------------------------------------------------
    always_comb begin
        pend_mask = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            pend_mask = pend_mask | w_pend_src[s];
        end
    end

    assign busy = |w_nonempty;

endmodule
`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_arbiter
// Description : Self-checking bench for writeback_arbiter. A queue-based
//               model predicts write ports, ready, pend_mask and busy; a
//               negedge compare process checks them every cycle, and directed
//               scenarios pin the model with literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_arbiter;

    localparam int NUM_SRC          = 8;
    localparam int NUM_WP           = 2;
    localparam int XLEN             = 32;
    localparam int NREG             = 32;
    localparam int DEPTH            = 4;
    localparam bit ZERO_REG_DISCARD = 1'b1;
    localparam int RW               = 5;

    logic                    clk = 1'b0;
    logic                    rstn = 1'b0;
    logic                    interlock = 1'b0;
    logic [NUM_SRC-1:0]      src_valid = '0;
    logic [NUM_SRC-1:0]      src_ready;
    logic [NUM_SRC*RW-1:0]   src_rd = '0;
    logic [NUM_SRC*XLEN-1:0] src_data = '0;
    logic [NUM_WP-1:0]       wp_en;
    logic [NUM_WP*RW-1:0]    wp_addr;
    logic [NUM_WP*XLEN-1:0]  wp_data;
    logic [NREG-1:0]         pend_mask;
    logic                    busy;

    always #5 clk = ~clk;

    writeback_arbiter #(
        .NUM_SRC          (NUM_SRC),
        .NUM_WP           (NUM_WP),
        .XLEN             (XLEN),
        .NREG             (NREG),
        .DEPTH            (DEPTH),
        .ZERO_REG_DISCARD (ZERO_REG_DISCARD)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .interlock (interlock),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src_rd    (src_rd),
        .src_data  (src_data),
        .wp_en     (wp_en),
        .wp_addr   (wp_addr),
        .wp_data   (wp_data),
        .pend_mask (pend_mask),
        .busy      (busy)
    );

    // ------------------------------------------------------------------------
    // Reference model: one queue per source, round-robin start index
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic [RW-1:0]   rd;
        logic [XLEN-1:0] data;
    } ent_t;

    ent_t            mq [NUM_SRC][$];
    int              m_rr = 0;
    logic [NUM_WP-1:0] e_en = '0;
    logic [RW-1:0]   e_addr [NUM_WP];
    logic [XLEN-1:0] e_data [NUM_WP];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_SRC; i++) mq[i].delete();
        m_rr = 0;
        e_en = '0;
    endtask

    // Advances the model across one rising edge using the current inputs.
    task automatic model_step();
        int   pre_size [NUM_SRC];
        int   used_rd [$];
        int   ng;
        int   last;
        int   s;
        bit   clash;
        ent_t h;
        ent_t e;
        if (!rstn) return;
        for (int i = 0; i < NUM_SRC; i++) pre_size[i] = mq[i].size();
        e_en = '0;
        ng   = 0;
        last = -1;
        if (!interlock) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                s = (m_rr + k) % NUM_SRC;
                if (ng < NUM_WP && mq[s].size() > 0) begin
                    h = mq[s][0];
                    clash = 1'b0;
                    foreach (used_rd[j]) if (used_rd[j] == int'(h.rd)) clash = 1'b1;
                    if (!clash) begin
                        used_rd.push_back(int'(h.rd));
                        e_en[ng]  = !(ZERO_REG_DISCARD && h.rd == '0);
                        e_addr[ng] = h.rd;
                        e_data[ng] = h.data;
                        void'(mq[s].pop_front());
                        last = s;
                        ng++;
                    end
                end
            end
        end
        if (last >= 0) m_rr = (last + 1) % NUM_SRC;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_valid[i] && pre_size[i] < DEPTH) begin
                e.rd   = src_rd[i*RW +: RW];
                e.data = src_data[i*XLEN +: XLEN];
                mq[i].push_back(e);
            end
        end
    endtask

    function automatic logic [NREG-1:0] exp_pend();
        logic [NREG-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_SRC; i++)
            foreach (mq[i][j]) m[mq[i][j].rd] = 1'b1;
        return m;
    endfunction

    function automatic logic exp_busy();
        logic b;
        b = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) if (mq[i].size() > 0) b = 1'b1;
        return b;
    endfunction

    function automatic logic [NUM_SRC-1:0] exp_ready();
        logic [NUM_SRC-1:0] r;
        for (int i = 0; i < NUM_SRC; i++) r[i] = (mq[i].size() < DEPTH);
        return r;
    endfunction

    // ------------------------------------------------------------------------
    // Compare process: every falling edge
    // ------------------------------------------------------------------------
    always @(negedge clk) begin
        chk("wp_en", 64'(wp_en), 64'(e_en));
        for (int k = 0; k < NUM_WP; k++) begin
            if (e_en[k]) begin
                chk("wp_addr", 64'(wp_addr[k*RW +: RW]), 64'(e_addr[k]));
                chk("wp_data", 64'(wp_data[k*XLEN +: XLEN]), 64'(e_data[k]));
            end
        end
        chk("pend_mask", 64'(pend_mask), 64'(exp_pend()));
        chk("busy", 64'(busy), 64'(exp_busy()));
        chk("src_ready", 64'(src_ready), 64'(exp_ready()));
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic tick();
        @(negedge clk);
        #1;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        src_valid = '0;
        src_rd    = '0;
        src_data  = '0;
    endtask

    task automatic put(input int s, input int rd, input logic [XLEN-1:0] data);
        src_valid[s]             = 1'b1;
        src_rd[s*RW +: RW]       = RW'(rd);
        src_data[s*XLEN +: XLEN] = data;
    endtask

    task automatic do_reset();
        clear_inputs();
        interlock = 1'b0;
        rstn = 1'b0;
        model_reset();
        tick();
        rstn = 1'b1;
    endtask

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin
        model_reset();
        repeat (2) tick();
        rstn = 1'b1;

        chk("rst_wp_en", 64'(wp_en), 64'd0);
        chk("rst_wp_addr", 64'(wp_addr), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_pend", 64'(pend_mask), 64'd0);
        chk("rst_ready", 64'(src_ready), 64'hFF);

        // Single write, one-cycle queue latency
        do_reset();
        put(0, 3, 32'hDEADBEEF);
        tick();
        clear_inputs();
        chk("t1_pend", 64'(pend_mask), 64'h8);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_en_early", 64'(wp_en), 64'd0);
        tick();
        chk("t1_en", 64'(wp_en), 64'b01);
        chk("t1_addr", 64'(wp_addr[RW-1:0]), 64'd3);
        chk("t1_data", 64'(wp_data[XLEN-1:0]), 64'hDEADBEEF);
        chk("t1_pend_clr", 64'(pend_mask), 64'd0);
        chk("t1_busy_clr", 64'(busy), 64'd0);

        // Three sources, two ports
        do_reset();
        put(0, 1, 32'hA1);
        put(1, 2, 32'hA2);
        put(2, 4, 32'hA4);
        tick();
        clear_inputs();
        tick();
        chk("t2_en_a", 64'(wp_en), 64'b11);
        chk("t2_addr0_a", 64'(wp_addr[RW-1:0]), 64'd1);
        chk("t2_addr1_a", 64'(wp_addr[2*RW-1:RW]), 64'd2);
        tick();
        chk("t2_en_b", 64'(wp_en), 64'b01);
        chk("t2_addr0_b", 64'(wp_addr[RW-1:0]), 64'd4);
        chk("t2_data0_b", 64'(wp_data[XLEN-1:0]), 64'hA4);

        // Same rd from two sources
        do_reset();
        put(0, 5, 32'hA);
        put(1, 5, 32'hB);
        tick();
        clear_inputs();
        tick();
        chk("t3_en_a", 64'(wp_en), 64'b01);
        chk("t3_addr_a", 64'(wp_addr[RW-1:0]), 64'd5);
        chk("t3_data_a", 64'(wp_data[XLEN-1:0]), 64'hA);
        tick();
        chk("t3_en_b", 64'(wp_en), 64'b01);
        chk("t3_data_b", 64'(wp_data[XLEN-1:0]), 64'hB);

        // Interlock with a full FIFO
        do_reset();
        interlock = 1'b1;
        for (int r = 6; r <= 9; r++) begin
            put(3, r, XLEN'(32'h100 + r));
            tick();
        end
        chk("t4_ready_full", 64'(src_ready[3]), 64'd0);
        put(3, 10, 32'h10A);
        tick();
        chk("t4_ready_still", 64'(src_ready[3]), 64'd0);
        chk("t4_en_held", 64'(wp_en), 64'd0);
        clear_inputs();
        interlock = 1'b0;
        for (int r = 6; r <= 9; r++) begin
            tick();
            chk("t4_en", 64'(wp_en), 64'b01);
            chk("t4_addr", 64'(wp_addr[RW-1:0]), 64'(r));
            if (r == 6) chk("t4_ready_back", 64'(src_ready[3]), 64'd1);
        end
        tick();
        chk("t4_no_fifth", 64'(wp_en), 64'd0);

        // Register-0 discard
        do_reset();
        put(0, 0, 32'h1234);
        tick();
        clear_inputs();
        chk("t5_pend0", 64'(pend_mask), 64'h1);
        tick();
        chk("t5_en", 64'(wp_en), 64'd0);
        chk("t5_pend", 64'(pend_mask), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);

        // Asynchronous reset mid-drain
        do_reset();
        interlock = 1'b1;
        for (int j = 0; j < 3; j++) begin
            for (int s = 0; s < 4; s++) put(s, 8 + 4 * j + s, XLEN'(32'h600 + 16 * j + s));
            tick();
        end
        clear_inputs();
        interlock = 1'b0;
        tick();
        chk("t6_draining", 64'(wp_en), 64'b11);
        @(negedge clk);
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        chk("t6_en", 64'(wp_en), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_pend", 64'(pend_mask), 64'd0);
        tick();
        rstn = 1'b1;
        repeat (3) tick();
        chk("t6_quiet", 64'(wp_en), 64'd0);
        put(0, 20, 32'h20);
        put(7, 21, 32'h21);
        tick();
        clear_inputs();
        tick();
        chk("t6_rr_en", 64'(wp_en), 64'b11);
        chk("t6_rr_port0", 64'(wp_addr[RW-1:0]), 64'd20);
        chk("t6_rr_port1", 64'(wp_addr[2*RW-1:RW]), 64'd21);

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            clear_inputs();
            interlock = ($urandom_range(0, 4) == 0);
            for (int s = 0; s < NUM_SRC; s++) begin
                if ($urandom_range(0, 99) < 35) put(s, int'($urandom_range(0, 7)), XLEN'($urandom()));
            end
            if ($urandom_range(0, 599) == 0) begin
                rstn = 1'b0;
                model_reset();
                tick();
                rstn = 1'b1;
            end else begin
                tick();
            end
        end
        clear_inputs();
        interlock = 1'b0;
        repeat (20) tick();
        chk("final_busy", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
Parametrised writeback stage that merges results from NUM_SRC producers (ALU lanes, load unit, fixed- and variable-latency FPU units) onto NUM_WP register-file write ports. Each producer has a small FIFO, so a result is never lost when more results arrive than there are write ports. Heads are granted with a round-robin scan that never grants two writes to the same register in one cycle. The block also exports a pending-write mask for the issue scoreboard and honours the pipeline interlock.

Parameters:
NUM_SRC, 8, number of result producers
NUM_WP, 2, number of register-file write ports (1..NUM_SRC)
XLEN, 32, data width
NREG, 32, number of registers; RW = $clog2(NREG) address bits
DEPTH, 4, entries per source FIFO (power of 2, >=2)
ZERO_REG_DISCARD, 1, if 1, writes to register 0 are consumed but never written

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
interlock  in  1  pipeline stall; no grants while high
src_valid  in  NUM_SRC  result valid, per source
src_ready  out  NUM_SRC  source FIFO can accept
src_rd  in  NUM_SRC*RW  destination register, source i at [i*RW +: RW]
src_data  in  NUM_SRC*XLEN  result data, source i at [i*XLEN +: XLEN]
wp_en  out  NUM_WP  write-port enable
wp_addr  out  NUM_WP*RW  write address per port
wp_data  out  NUM_WP*XLEN  write data per port
pend_mask  out  NREG  bit r=1 while any FIFO holds an entry with rd=r
busy  out  1  any FIFO non-empty

Behaviour:
- Reset (async, rstn=0): all FIFOs emptied, rr pointer=0, wp_en=0, wp_addr=0, wp_data=0, pend_mask=0, busy=0. Reset mid-drain discards all queued entries; no write is issued afterwards for them.
- Accept rule: an entry is accepted at a rising edge when src_valid[i] && src_ready[i].
  - src_ready[i] = (count[i] < DEPTH).
  - Ready is not raised by a same-cycle dequeue.
  - Enqueue and dequeue on the same FIFO in one cycle are legal; count is unchanged.
- FIFO: circular, pointers wrap modulo DEPTH, FIFO order is preserved per source. Full: count=DEPTH. Empty: count=0.
- Arbitration (combinational on FIFO heads, once per cycle, only when interlock=0):
  - Scan sources rr, rr+1, ..., rr+NUM_SRC-1 modulo NUM_SRC.
  - Grant a non-empty head unless its rd equals the rd of a head already granted this cycle. A skipped head stays queued.
  - Stop after NUM_WP grants.
  - The k-th grant in scan order drives port k; unused ports get en=0.
- rr update: rr <= (index of last granted source + 1) mod NUM_SRC. rr is unchanged when there are no grants.
- Outputs: wp_en, wp_addr and wp_data are registered; granted heads are popped at the same edge.
  - An entry accepted at edge k appears on wp_* after edge k+1 at the earliest (1 cycle queue latency). wp_en is held for exactly one cycle per write.
  - If ZERO_REG_DISCARD=1 and rd=0, the grant consumes a port and pops the entry, but that port's wp_en=0.
- Interlock=1: no grants and no pops; wp_en<=0 at the next edge. FIFOs keep accepting until full. rr is held.
- pend_mask and busy are combinational over all valid FIFO entries. A bit clears in the cycle after the pop edge, which is the same cycle wp_en for that write is high.
- Same rd from different sources in the same cycle: the write order follows scan order. The earlier-scanned write commits first, one cycle earlier.

Test Plan:
1. NUM_WP=2, src0 valid, rd=3, data=0xDEADBEEF at edge 0 -> after edge 1: wp_en=2'b01, wp_addr[0]=3, wp_data[0]=0xDEADBEEF; pend_mask[3]=1 only in the cycle between edges 0 and 1; busy=0 after edge 1.
2. Src0, src1, src2 valid together with rd=1, 2, 4 and rr=0 -> first write cycle: port0=src0 (rd1), port1=src1 (rd2), rr=2; next cycle: port0=src2 (rd4), port1 en=0, rr=3.
3. Src0 rd=5 data=0xA and src1 rd=5 data=0xB together -> first write cycle: only port0 writes rd5=0xA; next cycle: rd5=0xB.
4. interlock=1, src3 pushes rd 6,7,8,9 then offers a 5th entry -> src_ready[3]=0 after the 4th accept and wp_en stays 0. Release interlock -> writes 6,7,8,9 on consecutive cycles, src_ready[3] returns to 1 after the first pop.
5. ZERO_REG_DISCARD=1, src0 rd=0 data=0x1234 -> entry popped, wp_en=0, pend_mask[0] clears, busy=0.
6. Queue 3 entries on each of 4 sources, assert rstn=0 asynchronously mid-drain -> immediately wp_en=0, busy=0, pend_mask=0; after rstn=1 no further writes and rr=0.
